// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : EX/MEM pipeline stage with a valid/ready handshake and a
//                2-entry skid buffer. in_ready is a function of reset and
//                registered state only, so MEM back-pressure has no
//                combinational path to EX. A saturating counter records
//                cycles in which a valid bundle waits on MEM.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_mem_stage #(
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int PC_W   = 8,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   WB,
    input  logic [M_W-1:0]    M,
    input  logic [PC_W-1:0]   PC,
    input  logic              zero,
    input  logic [DATA_W-1:0] ALUresult,
    input  logic [DATA_W-1:0] writeData,
    input  logic [REG_W-1:0]  writeRegister,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   WB_output,
    output logic [M_W-1:0]    M_output,
    output logic [PC_W-1:0]   PC_output,
    output logic              zero_output,
    output logic [DATA_W-1:0] ALUresult_output,
    output logic [DATA_W-1:0] writeData_output,
    output logic [REG_W-1:0]  writeRegister_output,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Control fields (WB, M) sit in the upper bits of a bundle so a bubble
    // can zero them while the data fields below keep their last value.
    localparam int c_CTL_W  = WB_W + M_W;
    localparam int c_KEEP_W = PC_W + 1 + 2 * DATA_W + REG_W;
    localparam int c_BUN_W  = c_CTL_W + c_KEEP_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // State bits are {main_v, skid_v}; the (0,1) pattern is not encodable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } state_t;

    state_t               r_state;
    logic [c_BUN_W-1:0]   r_main;
    logic [c_BUN_W-1:0]   r_skid;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic                 w_main_v;
    logic                 w_skid_v;
    logic                 w_accept;
    logic                 w_drain;
    logic [c_BUN_W-1:0]   w_in;
    logic [c_BUN_W-1:0]   w_bubble;

    assign w_main_v = (r_state != ST_EMPTY);
    assign w_skid_v = (r_state == ST_SKID);
    assign in_ready = !rst && !w_skid_v;
    assign out_valid = w_main_v;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = w_main_v && out_ready;

    assign w_in     = {WB, M, PC, zero, ALUresult, writeData, writeRegister};
    assign w_bubble = {{c_CTL_W{1'b0}}, r_main[c_KEEP_W-1:0]};

    assign {WB_output, M_output, PC_output, zero_output,
            ALUresult_output, writeData_output, writeRegister_output} = r_main;
    assign stall_cnt = r_stall_cnt;

    // Slot occupancy and data movement; reset beats flush beats handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            r_main  <= w_bubble;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= w_in;
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_drain) begin
                        r_main <= w_in;
                    end else if (w_accept) begin
                        r_skid  <= w_in;
                        r_state <= ST_SKID;
                    end else if (w_drain) begin
                        r_main  <= w_bubble;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only the older entry moves.
                    if (w_drain) begin
                        r_main  <= r_skid;
                        r_state <= ST_FULL;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_main  <= w_bubble;
                end
            endcase
        end
    end

    // Saturating count of cycles where a valid bundle is held back by MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_v && !out_ready && !flush && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Self-checking bench for ex_mem_stage. A queue-based model
//                of the stage (bounded FIFO of depth 2 plus the last value
//                shown on the outputs) predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

    localparam int c_CNT_W   = 3;
    localparam int c_CNT_MAX = 7;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [7:0]  pc;
        logic        z;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
    } bundle_t;

    logic clk;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    bundle_t cur;
    logic [1:0]  WB_output;
    logic [2:0]  M_output;
    logic [7:0]  PC_output;
    logic        zero_output;
    logic [31:0] ALUresult_output, writeData_output;
    logic [4:0]  writeRegister_output;
    logic [c_CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bundle_t q[$];
    bundle_t shown;
    int      cnt;

    ex_mem_stage #(
        .WB_W(2), .M_W(3), .PC_W(8), .DATA_W(32), .REG_W(5), .CNT_W(c_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .WB(cur.wb), .M(cur.m), .PC(cur.pc), .zero(cur.z),
        .ALUresult(cur.alu), .writeData(cur.wd), .writeRegister(cur.wr),
        .out_valid(out_valid), .out_ready(out_ready),
        .WB_output(WB_output), .M_output(M_output), .PC_output(PC_output),
        .zero_output(zero_output), .ALUresult_output(ALUresult_output),
        .writeData_output(writeData_output),
        .writeRegister_output(writeRegister_output),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t rnd();
        bundle_t b;
        b.wb  = 2'($urandom);
        b.m   = 3'($urandom);
        b.pc  = 8'($urandom);
        b.z   = 1'($urandom);
        b.alu = $urandom;
        b.wd  = $urandom;
        b.wr  = 5'($urandom);
        return b;
    endfunction

    function automatic bundle_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu);
        bundle_t b;
        b = rnd();
        b.wb  = wb;
        b.m   = m;
        b.alu = alu;
        return b;
    endfunction

    // Model: the stage is a FIFO of at most two bundles whose head is shown
    // on the outputs; an empty FIFO shows zeroed control over the last data.
    task automatic model_edge();
        int  n;
        bit  acc, dr;
        if (rst) begin
            q.delete();
            shown = '0;
            cnt   = 0;
        end else if (flush) begin
            q.delete();
            shown.wb = '0;
            shown.m  = '0;
        end else begin
            n   = q.size();
            acc = in_valid && (n < 2);
            dr  = (n > 0) && out_ready;
            if (n > 0 && !out_ready && cnt < c_CNT_MAX) cnt++;
            if (dr) void'(q.pop_front());
            if (acc) q.push_back(cur);
            if (q.size() > 0) begin
                shown = q[0];
            end else begin
                shown.wb = '0;
                shown.m  = '0;
            end
        end
    endtask

    // Drive one cycle of inputs, check ready before the edge and every
    // output just after it.
    task automatic step(input logic r, input logic f, input logic iv, input logic orr, input bundle_t b);
        rst = r; flush = f; in_valid = iv; out_ready = orr; cur = b;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!r && (q.size() < 2)));
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("WB_output", 64'(WB_output), 64'(shown.wb));
        chk("M_output", 64'(M_output), 64'(shown.m));
        chk("PC_output", 64'(PC_output), 64'(shown.pc));
        chk("zero_output", 64'(zero_output), 64'(shown.z));
        chk("ALUresult_output", 64'(ALUresult_output), 64'(shown.alu));
        chk("writeData_output", 64'(writeData_output), 64'(shown.wd));
        chk("writeRegister_output", 64'(writeRegister_output), 64'(shown.wr));
        chk("stall_cnt", 64'(stall_cnt), 64'(cnt));
    endtask

    initial begin
        shown = '0;
        cnt   = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cur = '0;

        // Reset with random inputs, then release
        step(1, 0, 1, 1, rnd());
        step(1, 0, 1, 0, rnd());
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_alu", 64'(ALUresult_output), 64'd0);
        step(0, 0, 0, 1, rnd());

        // Streaming 0x11..0x44
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, 1, mk(2'b01, 3'b010, 32'h11 * i));
            chk("stream_alu", 64'(ALUresult_output), 64'(32'h11 * i));
        end
        step(0, 0, 0, 1, rnd());

        // Skid: A held, B into skid, C refused, then A, B, C in order
        step(0, 0, 1, 0, mk(2'b10, 3'b001, 32'hA));
        step(0, 0, 1, 0, mk(2'b10, 3'b001, 32'hB));
        chk("skid_in_ready", 64'(in_ready), 64'd0);
        step(0, 0, 1, 0, mk(2'b10, 3'b001, 32'hC));
        chk("skid_hold_A", 64'(ALUresult_output), 64'hA);
        step(0, 0, 1, 1, mk(2'b10, 3'b001, 32'hC));
        chk("skid_deliver_B", 64'(ALUresult_output), 64'hB);
        step(0, 0, 1, 1, mk(2'b10, 3'b001, 32'hC));
        chk("skid_deliver_C", 64'(ALUresult_output), 64'hC);
        step(0, 0, 0, 1, rnd());

        // Flush in SKID with a live input bundle
        step(0, 0, 1, 0, mk(2'b01, 3'b111, 32'h100));
        step(0, 0, 1, 0, mk(2'b01, 3'b111, 32'h200));
        step(0, 1, 1, 0, mk(2'b11, 3'b111, 32'h300));
        chk("flush_WB", 64'(WB_output), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        step(0, 0, 0, 1, rnd());

        // Bubble on drain
        step(0, 0, 1, 1, mk(2'b11, 3'b101, 32'h5A5));
        step(0, 0, 0, 1, rnd());
        chk("bubble_M", 64'(M_output), 64'd0);
        chk("bubble_alu", 64'(ALUresult_output), 64'h5A5);

        // Stall counter saturation, then reset clears it
        step(1, 0, 0, 0, rnd());
        step(0, 0, 1, 0, rnd());
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, rnd());
        chk("stall_sat", 64'(stall_cnt), 64'(c_CNT_MAX));
        step(1, 0, 0, 0, rnd());
        chk("stall_rst", 64'(stall_cnt), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 6),
                 rnd());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
